// File: rtl/axi_config_wr.sv
// AXI4 write slave that turns write bursts into single-cycle register write strobes.
// One burst at a time; one B response per burst, SLVERR when wlast disagrees with awlen.
module axi_config_wr #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 8,
  parameter int BUSER_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ID_WIDTH-1:0]    s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic [7:0]             s_axi_awlen,
  input  logic [2:0]             s_axi_awsize,
  input  logic [1:0]             s_axi_awburst,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]  s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [ID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic [BUSER_WIDTH-1:0] s_axi_buser,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  output logic                   wr,
  output logic [ADDR_WIDTH-1:0]  waddr,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [STRB_WIDTH-1:0]  wstrb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(BEAT_BYTES - {{(ADDR_WIDTH-1){1'b0}}, 1'b1});
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                state_r, state_s;
  logic                  awready_r, awready_s;
  logic                  wready_r, wready_s;
  logic                  bvalid_r, bvalid_s;
  logic [ID_WIDTH-1:0]   bid_r, bid_s;
  logic [1:0]            bresp_r, bresp_s;
  logic                  wr_r, wr_s;
  logic [ADDR_WIDTH-1:0] waddr_r, waddr_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [STRB_WIDTH-1:0] wstrb_r, wstrb_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [7:0]            len_r, len_s;
  logic [7:0]            cnt_r, cnt_s;
  logic                  fixed_r, fixed_s;
  logic                  err_r, err_s;
  logic [ID_WIDTH-1:0]   id_r, id_s;
  logic                  last_beat_s;
  logic                  unused_s;

  // Beat size is implied by the bus width, so awsize carries no information here.
  assign unused_s = ^s_axi_awsize;

  // Next-state and next-output decode for the burst FSM.
  always_comb begin
    state_s     = state_r;
    awready_s   = awready_r;
    wready_s    = wready_r;
    bvalid_s    = bvalid_r;
    bid_s       = bid_r;
    bresp_s     = bresp_r;
    wr_s        = 1'b0;
    waddr_s     = waddr_r;
    wdata_s     = wdata_r;
    wstrb_s     = wstrb_r;
    addr_s      = addr_r;
    len_s       = len_r;
    cnt_s       = cnt_r;
    fixed_s     = fixed_r;
    err_s       = err_r;
    id_s        = id_r;
    last_beat_s = (cnt_r == len_r);
    case (state_r)
      ST_IDLE: begin
        awready_s = 1'b1;
        if (s_axi_awvalid && awready_r) begin
          id_s      = s_axi_awid;
          len_s     = s_axi_awlen;
          fixed_s   = (s_axi_awburst == 2'b00);
          addr_s    = s_axi_awaddr & ALIGN_MASK;
          cnt_s     = 8'd0;
          err_s     = 1'b0;
          awready_s = 1'b0;
          wready_s  = 1'b1;
          state_s   = ST_DATA;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (s_axi_wvalid && wready_r) begin
          wr_s    = |s_axi_wstrb;
          waddr_s = addr_r;
          wdata_s = s_axi_wdata;
          wstrb_s = s_axi_wstrb;
          if (fixed_r) begin
            addr_s = addr_r;
          end else begin
            addr_s = addr_r + BEAT_BYTES;
          end
          err_s = err_r | (s_axi_wlast != last_beat_s);
          cnt_s = cnt_r + 8'd1;
          // Beat count alone ends the burst; wlast only feeds the error flag.
          if (last_beat_s) begin
            wready_s = 1'b0;
            bvalid_s = 1'b1;
            bid_s    = id_r;
            bresp_s  = err_s ? RESP_SLVERR : RESP_OKAY;
            state_s  = ST_RESP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_RESP: begin
        if (bvalid_r && s_axi_bready) begin
          bvalid_s  = 1'b0;
          awready_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update; async reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {ID_WIDTH{1'b0}};
      bresp_r   <= 2'b00;
      wr_r      <= 1'b0;
      waddr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
      wstrb_r   <= {STRB_WIDTH{1'b0}};
      addr_r    <= {ADDR_WIDTH{1'b0}};
      len_r     <= 8'd0;
      cnt_r     <= 8'd0;
      fixed_r   <= 1'b0;
      err_r     <= 1'b0;
      id_r      <= {ID_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      bid_r     <= bid_s;
      bresp_r   <= bresp_s;
      wr_r      <= wr_s;
      waddr_r   <= waddr_s;
      wdata_r   <= wdata_s;
      wstrb_r   <= wstrb_s;
      addr_r    <= addr_s;
      len_r     <= len_s;
      cnt_r     <= cnt_s;
      fixed_r   <= fixed_s;
      err_r     <= err_s;
      id_r      <= id_s;
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bid     = bid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_buser   = {BUSER_WIDTH{1'b0}};
  assign wr            = wr_r;
  assign waddr         = waddr_r;
  assign wdata         = wdata_r;
  assign wstrb         = wstrb_r;

endmodule

// File: tb/tb_axi_config_wr.sv
// Directed bench for axi_config_wr: hand-computed expectations checked with immediate assertions.
module tb_axi_config_wr;

  logic        clk;
  logic        rst_n;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata_in;
  logic [3:0]  wstrb_in;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic [0:0]  buser;
  logic        bvalid;
  logic        bready;
  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  int checks;
  int failures;
  int wr_count;

  axi_config_wr dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata_in), .s_axi_wstrb(wstrb_in), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wdata_in = d; wstrb_in = s; wlast = l; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic take_b();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; wr_count = 0;
    rst_n = 1'b0; awid = 8'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b0; wdata_in = 32'd0; wstrb_in = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // Reset state and release
    repeat (3) tick();
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_buser", 32'(buser), 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_awready_before_edge", 32'(awready), 32'd0);
    tick();
    chk("rel_awready", 32'(awready), 32'd1);

    // 1: single beat, unaligned address
    send_aw(8'h05, 32'h103, 8'd0, 2'b01);
    chk("t1_awready", 32'(awready), 32'd0);
    chk("t1_wready", 32'(wready), 32'd1);
    chk("t1_wr_idle", 32'(wr), 32'd0);
    beat(32'hDEADBEEF, 4'hF, 1'b1);
    chk("t1_wr", 32'(wr), 32'd1);
    chk("t1_waddr", waddr, 32'h100);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_wstrb", 32'(wstrb), 32'hF);
    chk("t1_bvalid", 32'(bvalid), 32'd1);
    chk("t1_bid", 32'(bid), 32'h5);
    chk("t1_bresp", 32'(bresp), 32'd0);
    chk("t1_wready_off", 32'(wready), 32'd0);
    take_b();
    chk("t1_bvalid_done", 32'(bvalid), 32'd0);
    chk("t1_awready_back", 32'(awready), 32'd1);
    chk("t1_wr_off", 32'(wr), 32'd0);

    // 2: INCR len=3, back-to-back beats
    send_aw(8'h02, 32'h1000, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wready", 32'(wready), 32'd1);
      chk("t2_bvalid_early", 32'(bvalid), 32'd0);
      beat(32'hC0DE0000 + 32'(i), 4'hF, (i == 3));
      chk("t2_wr", 32'(wr), 32'd1);
      chk("t2_waddr", waddr, 32'h1000 + 32'(4 * i));
      chk("t2_wdata", wdata, 32'hC0DE0000 + 32'(i));
    end
    chk("t2_bvalid", 32'(bvalid), 32'd1);
    chk("t2_bid", 32'(bid), 32'h2);
    chk("t2_bresp", 32'(bresp), 32'd0);
    take_b();
    tick();
    chk("t2_single_b", 32'(bvalid), 32'd0);

    // 3: FIXED len=1, second beat has no strobes
    send_aw(8'h03, 32'h20, 8'd1, 2'b00);
    beat(32'hA5A5A5A5, 4'hF, 1'b0);
    chk("t3_wr0", 32'(wr), 32'd1);
    chk("t3_waddr0", waddr, 32'h20);
    chk("t3_wdata0", wdata, 32'hA5A5A5A5);
    beat(32'h5A5A5A5A, 4'h0, 1'b1);
    chk("t3_wr1", 32'(wr), 32'd0);
    chk("t3_bvalid", 32'(bvalid), 32'd1);
    chk("t3_bresp", 32'(bresp), 32'd0);
    take_b();

    // 4: early wlast still gives three beats, then SLVERR
    send_aw(8'h04, 32'h0, 8'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      beat(32'h11110000 + 32'(i), 4'h3, (i == 1));
      chk("t4_wr", 32'(wr), 32'd1);
      chk("t4_waddr", waddr, 32'(4 * i));
      chk("t4_wstrb", 32'(wstrb), 32'h3);
    end
    chk("t4_bvalid", 32'(bvalid), 32'd1);
    chk("t4_bresp", 32'(bresp), 32'h2);
    take_b();
    send_aw(8'h06, 32'h40, 8'd0, 2'b01);
    beat(32'h12345678, 4'hF, 1'b1);
    chk("t4_clean_bresp", 32'(bresp), 32'd0);
    chk("t4_clean_bid", 32'(bid), 32'h6);
    take_b();

    // 5: response back-pressure with a pending AW
    send_aw(8'h07, 32'h200, 8'd0, 2'b01);
    beat(32'hFACEFACE, 4'hF, 1'b1);
    awid = 8'h08; awaddr = 32'h300; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_bvalid_hold", 32'(bvalid), 32'd1);
      chk("t5_bid_hold", 32'(bid), 32'h7);
      chk("t5_bresp_hold", 32'(bresp), 32'd0);
      chk("t5_awready_low", 32'(awready), 32'd0);
      chk("t5_wready_low", 32'(wready), 32'd0);
    end
    take_b();
    chk("t5_bvalid_done", 32'(bvalid), 32'd0);
    chk("t5_awready_back", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    chk("t5_aw_accepted", 32'(wready), 32'd1);
    beat(32'h0BADF00D, 4'hF, 1'b1);
    chk("t5_waddr", waddr, 32'h300);
    chk("t5_bid", 32'(bid), 32'h8);
    take_b();

    // 6: async reset during beat 2 of an 8-beat burst
    send_aw(8'h09, 32'h400, 8'd7, 2'b01);
    beat(32'h0, 4'hF, 1'b0);
    beat(32'h1, 4'hF, 1'b0);
    chk("t6_wr_before", 32'(wr), 32'd1);
    wdata_in = 32'h2; wstrb_in = 4'hF; wvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_wr_rst", 32'(wr), 32'd0);
    chk("t6_wready_rst", 32'(wready), 32'd0);
    chk("t6_bvalid_rst", 32'(bvalid), 32'd0);
    wvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 chk("t6_awready_pre", 32'(awready), 32'd0);
    tick();
    chk("t6_awready", 32'(awready), 32'd1);
    chk("t6_no_b", 32'(bvalid), 32'd0);
    send_aw(8'h0A, 32'h500, 8'd0, 2'b01);
    beat(32'h600DCAFE, 4'hF, 1'b1);
    chk("t6_wr", 32'(wr), 32'd1);
    chk("t6_waddr", waddr, 32'h500);
    chk("t6_bvalid", 32'(bvalid), 32'd1);
    chk("t6_bid", 32'(bid), 32'hA);
    chk("t6_bresp", 32'(bresp), 32'd0);
    take_b();

    // 7: awlen=255 with the address wrapping past the top of the map
    send_aw(8'h0B, 32'hFFFFFF00, 8'd255, 2'b01);
    for (int i = 0; i < 256; i++) begin
      beat(32'(i), 4'hF, (i == 255));
      if (wr) wr_count++;
      if (i == 254) chk("t7_bvalid_early", 32'(bvalid), 32'd0);
    end
    chk("t7_wr_count", 32'(wr_count), 32'd256);
    chk("t7_last_waddr", waddr, 32'h000002FC);
    chk("t7_last_wdata", wdata, 32'd255);
    chk("t7_bvalid", 32'(bvalid), 32'd1);
    chk("t7_bresp", 32'(bresp), 32'd0);
    take_b();
    chk("t7_awready", 32'(awready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
